// File: rtl/nl_sched.sv
// Round-robin scheduler that shares one nonlinear unit among NUM_REQ requesters.
// Define NL_SCHED_PRIO0_EN to give requester 0 absolute priority in IDLE.
module nl_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CMD_W   = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_err,
  output logic                     nl_valid,
  input  logic                     nl_ready,
  output logic [3:0]               nl_op,
  output logic [3:0]               nl_bubble,
  output logic [1:0]               nl_continuity,
  output logic [9:0]               nl_din_length,
  output logic [15:0]              nl_din_addr,
  output logic [3:0]               nl_win_length,
  output logic [5:0]               nl_win_addr,
  output logic [15:0]              nl_dout_addr,
  input  logic                     nl_done,
  output logic                     busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic [NUM_REQ-1:0]     r_req_done;
  logic [NUM_REQ-1:0]     r_req_err;
  logic                   r_nl_valid;
  logic                   r_busy;
  logic [3:0]             r_op;
  logic [3:0]             r_bubble;
  logic [1:0]             r_continuity;
  logic [9:0]             r_din_length;
  logic [15:0]            r_din_addr;
  logic [3:0]             r_win_length;
  logic [5:0]             r_win_addr;
  logic [15:0]            r_dout_addr;

  logic [CMD_W-1:0]       w_cmd_arr [NUM_REQ];
  logic [CMD_W-1:0]       w_cmd;
  logic                   w_gnt_any;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic [PTR_W-1:0]       w_gnt_next;
  logic [PTR_W-1:0]       w_owner_next;
  logic [NUM_REQ-1:0]     w_gnt_oh;
  logic [NUM_REQ-1:0]     w_owner_oh;
  logic                   w_illegal;
  logic                   w_can_grant;
  logic                   w_prio_grant;
  logic                   w_owner_prio;
  int unsigned            w_scan;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_cmd_arr[i] = req_cmd[i*CMD_W +: CMD_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_gnt_any    = 1'b0;
    w_gnt_idx    = '0;
    w_scan       = 0;
    w_prio_grant = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_gnt_any && req_valid[PTR_W'(w_scan)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PTR_W'(w_scan);
      end
    end
`ifdef NL_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      w_gnt_any    = 1'b1;
      w_gnt_idx    = '0;
      w_prio_grant = 1'b1;
    end
`endif
  end

`ifdef NL_SCHED_PRIO0_EN
  assign w_owner_prio = (r_owner == '0);
`else
  assign w_owner_prio = 1'b0;
`endif

  assign w_cmd        = w_cmd_arr[w_gnt_idx];
  assign w_illegal    = (w_cmd[59:56] > 4'd5);
  assign w_gnt_oh     = NUM_REQ'(1) << w_gnt_idx;
  assign w_owner_oh   = NUM_REQ'(1) << r_owner;
  assign w_gnt_next   = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
  assign w_owner_next = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + PTR_W'(1);
  // Hold off one cycle after any accept/done pulse so a requester can drop its valid.
  assign w_can_grant  = w_gnt_any && (r_req_ready == '0) && (r_req_done == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_req_ready  <= '0;
      r_req_done   <= '0;
      r_req_err    <= '0;
      r_nl_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_op         <= '0;
      r_bubble     <= '0;
      r_continuity <= '0;
      r_din_length <= '0;
      r_din_addr   <= '0;
      r_win_length <= '0;
      r_win_addr   <= '0;
      r_dout_addr  <= '0;
    end else begin
      r_req_ready <= '0;
      r_req_done  <= '0;
      r_req_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_can_grant) begin
            r_req_ready <= w_gnt_oh;
            if (w_illegal) begin
              r_req_err <= w_gnt_oh;
              if (!w_prio_grant) r_rr_ptr <= w_gnt_next;
            end else begin
              r_owner      <= w_gnt_idx;
              r_op         <= w_cmd[59:56];
              r_bubble     <= w_cmd[55:52];
              r_continuity <= w_cmd[51:50];
              r_din_length <= w_cmd[49:40];
              r_din_addr   <= w_cmd[39:24];
              r_win_length <= w_cmd[23:20];
              r_win_addr   <= w_cmd[19:14];
              r_dout_addr  <= {2'b00, w_cmd[13:0]};
              r_nl_valid   <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (nl_ready) begin
            r_nl_valid <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (nl_done) begin
            r_req_done <= w_owner_oh;
            if (!w_owner_prio) r_rr_ptr <= w_owner_next;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_nl_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign req_done      = r_req_done;
  assign req_err       = r_req_err;
  assign nl_valid      = r_nl_valid;
  assign busy          = r_busy;
  assign nl_op         = r_op;
  assign nl_bubble     = r_bubble;
  assign nl_continuity = r_continuity;
  assign nl_din_length = r_din_length;
  assign nl_din_addr   = r_din_addr;
  assign nl_win_length = r_win_length;
  assign nl_win_addr   = r_win_addr;
  assign nl_dout_addr  = r_dout_addr;

endmodule

// File: tb/tb_nl_sched.sv
// Directed self-checking bench for nl_sched (NUM_REQ=4, CMD_W=60).
module tb_nl_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 60;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*CW-1:0] req_cmd;
  logic [NR-1:0]  req_ready, req_done, req_err;
  logic           nl_valid, nl_ready, nl_done, busy;
  logic [3:0]     nl_op, nl_bubble, nl_win_length;
  logic [1:0]     nl_continuity;
  logic [9:0]     nl_din_length;
  logic [15:0]    nl_din_addr, nl_dout_addr;
  logic [5:0]     nl_win_addr;

  int n_tests = 0;
  int n_fail  = 0;

  nl_sched #(.NUM_REQ(NR), .CMD_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .nl_valid(nl_valid), .nl_ready(nl_ready),
    .nl_op(nl_op), .nl_bubble(nl_bubble), .nl_continuity(nl_continuity),
    .nl_din_length(nl_din_length), .nl_din_addr(nl_din_addr),
    .nl_win_length(nl_win_length), .nl_win_addr(nl_win_addr),
    .nl_dout_addr(nl_dout_addr), .nl_done(nl_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] mk_cmd(input logic [3:0] op, input logic [13:0] dout);
    return {op, 4'h1, 2'b01, 10'd8, 16'h0100, 4'd3, 6'd5, dout};
  endfunction

  task automatic set_cmd(input int idx, input logic [59:0] c);
    req_cmd[idx*CW +: CW] = c;
  endtask

  function automatic logic [61:0] fields();
    return {nl_op, nl_bubble, nl_continuity, nl_din_length, nl_din_addr,
            nl_win_length, nl_win_addr, nl_dout_addr};
  endfunction

  // Wait a bounded number of cycles for an accept pulse; 0 on timeout.
  task automatic grant_wait(output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
    end
  endtask

  // From ISSUE: handshake, stay in BUSY, then nl_done; returns the done pulse.
  task automatic finish_cmd(output logic [NR-1:0] d);
    nl_ready = 1'b1;
    tick();
    nl_ready = 1'b0;
    tick();
    tick();
    nl_done = 1'b1;
    tick();
    d = req_done;
    nl_done = 1'b0;
    tick();
  endtask

  logic [NR-1:0] g, d;
  logic [61:0]   exp_f;

  initial begin
    rst = 1'b1; req_valid = '0; req_cmd = '0; nl_ready = 1'b0; nl_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_outs", {60'd0, req_ready} | {req_done, req_err, nl_valid, busy}, 64'd0);
    check("reset_fields", 64'(fields()), 64'd0);
    tick(); tick();
    rst = 1'b1;

    // Single requester 2, op=3, nl_ready high.
    set_cmd(2, mk_cmd(4'd3, 14'h0ABC));
    req_valid = 4'b0100;
    nl_ready = 1'b1;
    tick();
    check("a_ready", 64'(req_ready), 64'h4);
    check("a_err", 64'(req_err), 64'h0);
    check("a_nlvalid", 64'(nl_valid), 64'h1);
    check("a_op_dout", 64'({nl_op, nl_dout_addr}), 64'h30ABC);
    req_valid = '0;
    tick();
    check("a_one_valid", 64'({nl_valid, busy}), 64'h1);
    nl_ready = 1'b0;
    tick(); tick(); tick();
    nl_done = 1'b1;
    tick();
    check("a_done", 64'(req_done), 64'h4);
    nl_done = 1'b0;
    tick();
    check("a_idle", 64'({busy, req_done}), 64'h0);

    // Spurious nl_done in IDLE, then requesters {0,1} with rr_ptr=3 wraps to 0.
    nl_done = 1'b1;
    tick();
    nl_done = 1'b0;
    check("spur_done", 64'({req_done, busy}), 64'h0);
    set_cmd(0, mk_cmd(4'd0, 14'h0010));
    set_cmd(1, mk_cmd(4'd1, 14'h0011));
    req_valid = 4'b0011;
    grant_wait(g);
    check("wrap_grant", 64'(g), 64'h1);
    req_valid = '0;
    finish_cmd(d);
    check("wrap_done", 64'(d), 64'h1);

    // Illegal op on requester 1: err and ready together, no issue.
    set_cmd(1, mk_cmd(4'd9, 14'h0022));
    req_valid = 4'b0010;
    tick();
    check("err_ready", 64'({req_ready, req_err}), 64'h22);
    check("err_noissue", 64'({nl_valid, busy}), 64'h0);
    req_valid = '0;
    tick();
    check("err_once", 64'({req_ready, req_err, busy}), 64'h0);
    set_cmd(0, mk_cmd(4'd2, 14'h0030));
    set_cmd(2, mk_cmd(4'd4, 14'h0032));
    req_valid = 4'b0101;
    grant_wait(g);
`ifdef NL_SCHED_PRIO0_EN
    check("err_next", 64'(g), 64'h1);
`else
    check("err_next", 64'(g), 64'h4);
`endif
    req_valid = '0;
    finish_cmd(d);
    check("err_next_done", 64'(d), 64'(g));

    // Back-pressure: nl_ready low for 5 cycles in ISSUE.
    set_cmd(3, {4'd1, 4'hA, 2'b10, 10'h155, 16'hBEEF, 4'h7, 6'h2D, 14'h1234});
    exp_f = {4'd1, 4'hA, 2'b10, 10'h155, 16'hBEEF, 4'h7, 6'h2D, 16'h1234};
    req_valid = 4'b1000;
    grant_wait(g);
    check("bp_grant", 64'(g), 64'h8);
    req_valid = '0;
    set_cmd(3, '0);
    for (int i = 0; i < 5; i++) begin
      check("bp_fields", 64'(fields()), 64'(exp_f));
      check("bp_valid", 64'({nl_valid, busy}), 64'h3);
      tick();
    end
    nl_ready = 1'b1;
    tick();
    nl_ready = 1'b0;
    check("bp_busy", 64'({nl_valid, busy}), 64'h1);
    check("bp_hold", 64'(fields()), 64'(exp_f));

    // Asynchronous reset during BUSY with owner 3.
    #2 rst = 1'b0;
    #1;
    check("arst_outs", 64'({req_ready, req_done, req_err, nl_valid, busy}), 64'h0);
    check("arst_fields", 64'(fields()), 64'd0);
    nl_done = 1'b1;
    tick();
    check("arst_nodone", 64'(req_done), 64'h0);
    nl_done = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_idle", 64'({req_done, busy}), 64'h0);

    // All four valid with legal ops: grant order from requester 0.
    for (int i = 0; i < 4; i++) set_cmd(i, mk_cmd(4'(i), 14'(i)));
    req_valid = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      grant_wait(g);
`ifdef NL_SCHED_PRIO0_EN
      check("rr_grant", 64'(g), 64'h1);
`else
      check("rr_grant", 64'(g), 64'(4'b0001 << n));
`endif
      finish_cmd(d);
      check("rr_done", 64'(d), 64'(g));
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
